baud_tick_gen: RTL and testbench

- Parametrised successor of the fixed divide-by-652 UART clock divider.
- Generates a single-cycle oversample tick (tick_os), a bit-rate tick (tick_baud) and a legacy square wave (clk_out) from the system clock.
- The divisor is runtime-programmable with glitch-free reload, and a phase-resync input allows RX start-bit alignment.
- Sits between the system clock and the UART TX/RX datapaths.

---
 rtl/baud_tick_gen.sv | 161 ++++++++++++++++
 tb/tb_baud_tick_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// UART baud tick generator: prescaler -> oversample tick -> bit tick, with shadowed divisor reload and resync.
// Optional fractional divider enabled by defining BAUD_FRAC_DIV_EN.
module baud_tick_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 651,
    parameter int OVERSAMPLE  = 16
`ifdef BAUD_FRAC_DIV_EN
    ,
    parameter int FRAC_WIDTH  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 div_load,
    input  logic                 resync,
`ifdef BAUD_FRAC_DIV_EN
    input  logic [FRAC_WIDTH-1:0] frac_value,
`endif
    output logic                 tick_os,
    output logic                 tick_baud,
    output logic                 clk_out,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 load_pending
);

    localparam int OS_W = $clog2(OVERSAMPLE);
`ifdef BAUD_FRAC_DIV_EN
    // One spare bit so an extended period at the maximum divisor cannot wrap.
    localparam int CNT_W = DIV_WIDTH + 1;
`else
    localparam int CNT_W = DIV_WIDTH;
`endif

    logic [CNT_W-1:0]     cnt_q, cnt_d, term;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [DIV_WIDTH-1:0] div_active_q, div_active_d;
    logic [DIV_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pend_q, pend_d;
    logic                 tick_os_q, tick_os_d;
    logic                 tick_baud_q, tick_baud_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tc;

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_WIDTH-1:0] acc_q, acc_d, acc_next;
    logic                  ext_q, ext_d;

    assign term     = {1'b0, div_active_q} + CNT_W'(ext_q);
    assign acc_next = acc_q + frac_value;
`else
    assign term = div_active_q;
`endif

    assign tc = enable && (cnt_q == term);

    always_comb begin
        cnt_d        = cnt_q;
        os_cnt_d     = os_cnt_q;
        div_active_d = div_active_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        tick_os_d    = 1'b0;
        tick_baud_d  = 1'b0;
        clk_out_d    = clk_out_q;
`ifdef BAUD_FRAC_DIV_EN
        acc_d        = acc_q;
        ext_d        = ext_q;
`endif
        if (resync) begin
            cnt_d    = '0;
            os_cnt_d = '0;
`ifdef BAUD_FRAC_DIV_EN
            acc_d    = '0;
            ext_d    = 1'b0;
`endif
            if (div_load) begin
                div_active_d = div_value;
                shadow_d     = div_value;
                pend_d       = 1'b0;
            end else if (pend_q) begin
                div_active_d = shadow_q;
                pend_d       = 1'b0;
            end
        end else begin
            if (enable) begin
                if (tc) begin
                    cnt_d     = '0;
                    tick_os_d = 1'b1;
                    clk_out_d = ~clk_out_q;
                    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
                        os_cnt_d    = '0;
                        tick_baud_d = 1'b1;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                    if (pend_q) begin
                        div_active_d = shadow_q;
                        pend_d       = 1'b0;
                    end
`ifdef BAUD_FRAC_DIV_EN
                    // Extend the coming period when its own accumulation will carry,
                    // so the first period after reset/resync is never stretched.
                    acc_d = acc_next;
                    ext_d = (acc_next > ~frac_value);
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Evaluated after the swap so a load on the terminal edge stays pending.
            if (div_load) begin
                shadow_d = div_value;
                if (enable) begin
                    pend_d = 1'b1;
                end else begin
                    div_active_d = div_value;
                    pend_d       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            os_cnt_q     <= '0;
            div_active_q <= DIV_WIDTH'(DEFAULT_DIV);
            shadow_q     <= DIV_WIDTH'(DEFAULT_DIV);
            pend_q       <= 1'b0;
            tick_os_q    <= 1'b0;
            tick_baud_q  <= 1'b0;
            clk_out_q    <= 1'b0;
`ifdef BAUD_FRAC_DIV_EN
            acc_q        <= '0;
            ext_q        <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            os_cnt_q     <= os_cnt_d;
            div_active_q <= div_active_d;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            tick_os_q    <= tick_os_d;
            tick_baud_q  <= tick_baud_d;
            clk_out_q    <= clk_out_d;
`ifdef BAUD_FRAC_DIV_EN
            acc_q        <= acc_d;
            ext_q        <= ext_d;
`endif
        end
    end

    assign tick_os      = tick_os_q;
    assign tick_baud    = tick_baud_q;
    assign clk_out      = clk_out_q;
    assign div_active   = div_active_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: short per-cycle vector table plus long-period sequences.
// Frac sequence runs only when BAUD_FRAC_DIV_EN is defined.
module tb_baud_tick_gen;

    logic        clk = 1'b0;
    logic        rst, enable, div_load, resync;
    logic [15:0] div_value;
    logic        tick_os, tick_baud, clk_out, load_pending;
    logic [15:0] div_active;
`ifdef BAUD_FRAC_DIV_EN
    logic [3:0]  frac_value;
`endif

    int passed = 0;
    int total  = 0;
    int bad_baud = 0;

    baud_tick_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .div_value(div_value),
        .div_load(div_load), .resync(resync),
`ifdef BAUD_FRAC_DIV_EN
        .frac_value(frac_value),
`endif
        .tick_os(tick_os), .tick_baud(tick_baud), .clk_out(clk_out),
        .div_active(div_active), .load_pending(load_pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tick_baud && !tick_os) bad_baud = 1;

    typedef struct {
        logic        rst, en, load, rsync;
        logic [15:0] dv;
        logic        tick, baud, clko;
        logic [15:0] diva;
        logic        pend;
    } vec_t;

    vec_t vt[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; div_load = 1'b0; resync = 1'b0; div_value = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic count_to_tick(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_os && n < max);
        if (!tick_os) $display("FAIL timeout: no tick_os within %0d cycles", max);
    endtask

    initial begin
        int n, m, pc, tc, nb, kb, ticks, bauds, firstb;
        rst = 1'b1; enable = 1'b0; div_load = 1'b0; resync = 1'b0; div_value = '0;
`ifdef BAUD_FRAC_DIV_EN
        frac_value = '0;
`endif
        //          rst  en   load rs   dv      tick baud clk  diva    pend
        vt[0]  = '{1'b1,1'b0,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b0,16'd651,1'b0};
        vt[1]  = '{1'b0,1'b0,1'b1,1'b0,16'd2,  1'b0,1'b0,1'b0,16'd2,  1'b0};
        vt[2]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b0,16'd2,  1'b0};
        vt[3]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b0,16'd2,  1'b0};
        vt[4]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b1,16'd2,  1'b0};
        vt[5]  = '{1'b0,1'b1,1'b1,1'b0,16'd1,  1'b0,1'b0,1'b1,16'd2,  1'b1};
        vt[6]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b1,16'd2,  1'b1};
        vt[7]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b0,16'd1,  1'b0};
        vt[8]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b0,16'd1,  1'b0};
        vt[9]  = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b1,16'd1,  1'b0};
        vt[10] = '{1'b0,1'b0,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b1,16'd1,  1'b0};
        vt[11] = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b1,16'd1,  1'b0};
        vt[12] = '{1'b0,1'b1,1'b0,1'b1,16'd0,  1'b0,1'b0,1'b1,16'd1,  1'b0};
        vt[13] = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b0,1'b0,1'b1,16'd1,  1'b0};
        vt[14] = '{1'b0,1'b1,1'b0,1'b0,16'd0,  1'b1,1'b0,1'b0,16'd1,  1'b0};
        vt[15] = '{1'b0,1'b1,1'b1,1'b1,16'd3,  1'b0,1'b0,1'b0,16'd3,  1'b0};
        vt[16] = '{1'b1,1'b1,1'b1,1'b0,16'd5,  1'b0,1'b0,1'b0,16'd651,1'b0};

        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rst; enable = vt[i].en; div_load = vt[i].load;
            resync = vt[i].rsync; div_value = vt[i].dv;
            step();
            check($sformatf("vec%0d {tick,baud,clk,diva,pend}", i),
                  {tick_os, tick_baud, clk_out, div_active, load_pending},
                  {vt[i].tick, vt[i].baud, vt[i].clko, vt[i].diva, vt[i].pend});
        end

        // Defaults: tick every 652, clk_out period 1304, baud every 10432.
        do_reset();
        check("clk_out low after reset", clk_out, 0);
        enable = 1'b1;
        count_to_tick(700, n);
        check("first tick period", n, 652);
        check("clk_out after first tick", clk_out, 1);
        count_to_tick(700, n);
        check("second tick period", n, 652);
        check("clk_out after second tick", clk_out, 0);
        tc = 1304; nb = 0;
        for (int k = 3; k <= 16; k++) begin
            count_to_tick(700, n);
            tc += n;
            if (k < 16 && tick_baud) nb++;
        end
        check("early tick_baud count", nb, 0);
        check("tick_baud on 16th tick", tick_baud, 1);
        check("tick_baud cycles", tc, 10432);

        // Mid-period reload at cnt=300.
        do_reset();
        enable = 1'b1;
        repeat (300) step();
        div_value = 16'd9; div_load = 1'b1;
        step();
        div_load = 1'b0;
        pc = load_pending ? 1 : 0;
        m = 0;
        do begin
            step();
            m++;
            if (load_pending) pc++;
        end while (!tick_os && m < 700);
        check("reload period not truncated", 301 + m, 652);
        check("load_pending cycles", pc, 351);
        check("div_active after swap", div_active, 9);
        count_to_tick(50, n);
        check("new period 1", n, 10);
        count_to_tick(50, n);
        check("new period 2", n, 10);

        // div=0 loaded while disabled: immediate swap, tick every cycle.
        do_reset();
        div_value = 16'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("div0 immediate", div_active, 0);
        check("div0 no pending", load_pending, 0);
        enable = 1'b1;
        ticks = 0; bauds = 0; firstb = 0;
        for (int i = 1; i <= 32; i++) begin
            step();
            ticks += tick_os;
            if (tick_baud) begin
                bauds++;
                if (firstb == 0) firstb = i;
            end
        end
        check("div0 ticks in 32", ticks, 32);
        check("div0 bauds in 32", bauds, 2);
        check("div0 first baud", firstb, 16);

        // Enable dropped at cnt=100 for 50 cycles.
        do_reset();
        enable = 1'b1;
        repeat (100) step();
        enable = 1'b0;
        tc = 0;
        repeat (50) begin
            step();
            tc += tick_os | tick_baud;
        end
        check("ticks while disabled", tc, 0);
        enable = 1'b1;
        count_to_tick(700, n);
        check("resume phase", n, 552);

        // resync + load 20 at cnt=400 after one tick.
        do_reset();
        enable = 1'b1;
        count_to_tick(700, n);
        repeat (400) step();
        div_value = 16'd20; div_load = 1'b1; resync = 1'b1;
        step();
        div_load = 1'b0; resync = 1'b0;
        check("resync div_active", div_active, 20);
        check("resync tick low", tick_os, 0);
        check("resync clk_out held", clk_out, 1);
        count_to_tick(100, n);
        check("resync first tick", n, 21);
        check("clk_out toggles after resync", clk_out, 0);
        kb = 0;
        for (int k = 2; k <= 20 && kb == 0; k++) begin
            count_to_tick(100, n);
            if (tick_baud) kb = k;
        end
        check("os_cnt restarted", kb, 16);

`ifdef BAUD_FRAC_DIV_EN
        begin
            int p1, p2, sum;
            do_reset();
            frac_value = 4'd8;
            div_value = 16'd9; div_load = 1'b1;
            step();
            div_load = 1'b0;
            enable = 1'b1;
            count_to_tick(50, p1);
            count_to_tick(50, p2);
            sum = p1 + p2;
            repeat (30) begin
                count_to_tick(50, n);
                sum += n;
            end
            check("frac period 1", p1, 10);
            check("frac period 2", p2, 11);
            check("frac 32 ticks", sum, 336);
        end
`endif

        check("tick_baud without tick_os", bad_baud, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
